// File: rtl/trace_cmd_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_cmd_scheduler_if : trace command intake and L2 request/completion bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface trace_cmd_scheduler_if #(
  parameter int ADDR_W = 32
) ();
  logic              cmd_valid;
  logic [3:0]        cmd_code;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_ready;
  logic              l2_req_valid;
  logic [3:0]        l2_req_op;
  logic [ADDR_W-1:0] l2_req_addr;
  logic              l2_req_ready;
  logic              l2_done;

  // master: the scheduler; slave: trace reader plus L2 controller
  modport master (
    input  cmd_valid, cmd_code, cmd_addr, l2_req_ready, l2_done,
    output cmd_ready, l2_req_valid, l2_req_op, l2_req_addr
  );

  modport slave (
    output cmd_valid, cmd_code, cmd_addr, l2_req_ready, l2_done,
    input  cmd_ready, l2_req_valid, l2_req_op, l2_req_addr
  );
endinterface
`default_nettype wire

// File: rtl/trace_cmd_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// trace_cmd_scheduler : queues L1/snoop trace commands and issues them to L2
// one at a time with snoop priority, starvation guard and barriers.
// Revision 1.0
// ---------------------------------------------------------------------------
module trace_cmd_scheduler #(
  parameter int ADDR_W      = 32,
  parameter int QDEPTH      = 4,
  parameter int SNOOP_BURST = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  trace_cmd_scheduler_if.master bus,
  output logic                 busy,
  output logic [15:0]          issued_count,
  output logic [7:0]           dropped_count
);
  localparam int AW = $clog2(QDEPTH);
  localparam int PW = AW + 1;
  localparam int SW = $clog2(SNOOP_BURST + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Index 0 is the L1 request queue, index 1 the snoop queue.
  logic [1:0]             q_empty;
  logic [1:0]             q_full;
  logic [1:0]             q_enq;
  logic [1:0]             q_deq;
  logic [1:0][3:0]        head_op;
  logic [1:0][ADDR_W-1:0] head_addr;

  logic              is_l1, is_snp, is_bar, is_ill;
  logic              ready, accept;
  logic              barrier_pend;
  logic [3:0]        barrier_code;
  logic [SW-1:0]     streak;
  logic [3:0]        cur_op;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_bar;
  logic              sel_bar, sel_l1, sel_snp;

  always_comb begin
    is_l1  = 1'b0;
    is_snp = 1'b0;
    is_bar = 1'b0;
    is_ill = 1'b0;
    ready  = 1'b1;
    case (bus.cmd_code)
      4'd0, 4'd1, 4'd2: begin
        is_l1 = 1'b1;
        ready = !q_full[0] && !barrier_pend;
      end
      4'd3, 4'd4, 4'd5, 4'd6: begin
        is_snp = 1'b1;
        ready  = !q_full[1] && !barrier_pend;
      end
      4'd8, 4'd9: begin
        is_bar = 1'b1;
        ready  = !barrier_pend;
      end
      default: begin
        is_ill = 1'b1;
        ready  = 1'b1;
      end
    endcase
  end

  assign accept        = bus.cmd_valid && ready;
  assign bus.cmd_ready = ready;
  assign q_enq         = {accept && is_snp, accept && is_l1};
  assign q_deq         = {sel_snp, sel_l1};

  for (genvar q = 0; q < 2; q++) begin : g_queue
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [3:0]        op_mem   [QDEPTH];
    logic [ADDR_W-1:0] addr_mem [QDEPTH];

    assign q_empty[q]   = (head == tail);
    assign q_full[q]    = (head[AW] != tail[AW]) && (head[AW-1:0] == tail[AW-1:0]);
    assign head_op[q]   = op_mem[head[AW-1:0]];
    assign head_addr[q] = addr_mem[head[AW-1:0]];

    always_ff @(posedge clk) begin
      if (reset) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (q_enq[q]) tail <= tail + PW'(1);
        if (q_deq[q]) head <= head + PW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (q_enq[q]) begin
        op_mem[tail[AW-1:0]]   <= bus.cmd_code;
        addr_mem[tail[AW-1:0]] <= bus.cmd_addr;
      end
    end
  end

  // Selection only looks at registered queue state, so a command enqueued
  // on the same edge as a dequeue waits one more cycle to be seen.
  always_comb begin
    state_nxt = state;
    sel_bar   = 1'b0;
    sel_l1    = 1'b0;
    sel_snp   = 1'b0;
    case (state)
      IDLE: begin
        if (barrier_pend && (q_empty == 2'b11)) begin
          sel_bar = 1'b1;
        end else if (!q_empty[0] && (streak == SW'(SNOOP_BURST))) begin
          sel_l1 = 1'b1;
        end else if (!q_empty[1]) begin
          sel_snp = 1'b1;
        end else if (!q_empty[0]) begin
          sel_l1 = 1'b1;
        end
        if (sel_bar || sel_l1 || sel_snp) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (bus.l2_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.l2_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cur_op        <= '0;
      cur_addr      <= '0;
      cur_bar       <= 1'b0;
      streak        <= '0;
      barrier_pend  <= 1'b0;
      barrier_code  <= '0;
      issued_count  <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_nxt;

      if (sel_bar) begin
        cur_op   <= barrier_code;
        cur_addr <= '0;
        cur_bar  <= 1'b1;
      end else if (sel_l1) begin
        cur_op   <= head_op[0];
        cur_addr <= head_addr[0];
        cur_bar  <= 1'b0;
      end else if (sel_snp) begin
        cur_op   <= head_op[1];
        cur_addr <= head_addr[1];
        cur_bar  <= 1'b0;
      end

      // Streak only grows while an L1 request is actually being passed over.
      if (sel_snp) begin
        streak <= q_empty[0] ? '0 : streak + SW'(1);
      end else if (sel_l1 || sel_bar) begin
        streak <= '0;
      end

      if ((state == ISSUE) && bus.l2_req_ready) issued_count <= issued_count + 16'd1;

      if ((state == WAIT) && bus.l2_done && cur_bar) begin
        barrier_pend <= 1'b0;
      end else if (accept && is_bar) begin
        barrier_pend <= 1'b1;
        barrier_code <= bus.cmd_code;
      end

      if (accept && is_ill && (dropped_count != 8'hFF)) dropped_count <= dropped_count + 8'd1;
    end
  end

  assign bus.l2_req_valid = (state == ISSUE);
  assign bus.l2_req_op    = cur_op;
  assign bus.l2_req_addr  = cur_addr;
  assign busy             = (q_empty != 2'b11) || barrier_pend || (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trace_cmd_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_trace_cmd_scheduler : scoreboard bench with a queue-based reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_trace_cmd_scheduler;
  localparam int AW = 32;
  localparam int QD = 4;
  localparam int SB = 3;

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] addr;
  } req_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [15:0] issued_count;
  logic [7:0]  dropped_count;

  always #5 clk = ~clk;

  trace_cmd_scheduler_if #(.ADDR_W(AW)) bus ();

  trace_cmd_scheduler #(.ADDR_W(AW), .QDEPTH(QD), .SNOOP_BURST(SB)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .issued_count (issued_count),
    .dropped_count(dropped_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: plain queues plus a phase (0 idle, 1 offering, 2 awaiting done)
  req_t exp_q[$];
  req_t seen[$];
  req_t l1_m[$];
  req_t snp_m[$];
  int         m_phase;
  bit         m_bpend;
  logic [3:0] m_bcode;
  bit         m_cur_bar;
  int         m_streak;
  int         m_issued;
  int         m_dropped;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic req_t mk(logic [3:0] op, logic [AW-1:0] a);
    req_t r;
    r.op   = op;
    r.addr = a;
    return r;
  endfunction

  function automatic bit model_ready(logic [3:0] c);
    if (c <= 4'd2) return (l1_m.size() < QD) && !m_bpend;
    if (c <= 4'd6) return (snp_m.size() < QD) && !m_bpend;
    if (c == 4'd8 || c == 4'd9) return !m_bpend;
    return 1'b1;
  endfunction

  function automatic bit model_idle();
    return (m_phase == 0) && (l1_m.size() == 0) && (snp_m.size() == 0) && !m_bpend;
  endfunction

  function automatic void model_reset();
    l1_m.delete();
    snp_m.delete();
    exp_q.delete();
    m_phase   = 0;
    m_bpend   = 0;
    m_bcode   = '0;
    m_cur_bar = 0;
    m_streak  = 0;
    m_issued  = 0;
    m_dropped = 0;
  endfunction

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_code     = '0;
    bus.cmd_addr     = '0;
    bus.l2_req_ready = 1'b0;
    bus.l2_done      = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, compare against model state, advance the model.
  task automatic step(input bit v, input logic [3:0] c, input logic [AW-1:0] a,
                      input bit rdy, input bit dn, output bit acc);
    bit   exp_rdy;
    bit   got;
    bit   bar;
    req_t g;
    @(posedge clk);
    #1;
    reset            = 1'b0;
    bus.cmd_valid    = v;
    bus.cmd_code     = c;
    bus.cmd_addr     = a;
    bus.l2_req_ready = rdy;
    bus.l2_done      = dn;
    #1;
    exp_rdy = model_ready(c);
    check("cmd_ready", bus.cmd_ready, exp_rdy);
    check("l2_req_valid", bus.l2_req_valid, m_phase == 1);
    check("busy", busy, (l1_m.size() != 0) || (snp_m.size() != 0) || m_bpend || (m_phase != 0));
    check("issued_count", issued_count, m_issued % 65536);
    check("dropped_count", dropped_count, m_dropped);
    acc = v && exp_rdy;
    got = 0;
    bar = 0;
    g   = '0;
    case (m_phase)
      0: begin
        if (m_bpend && l1_m.size() == 0 && snp_m.size() == 0) begin
          g = mk(m_bcode, '0); got = 1; bar = 1; m_streak = 0;
        end else if (l1_m.size() != 0 && m_streak == SB) begin
          g = l1_m.pop_front(); got = 1; m_streak = 0;
        end else if (snp_m.size() != 0) begin
          m_streak = (l1_m.size() != 0) ? m_streak + 1 : 0;
          g = snp_m.pop_front(); got = 1;
        end else if (l1_m.size() != 0) begin
          g = l1_m.pop_front(); got = 1; m_streak = 0;
        end
        if (got) begin
          exp_q.push_back(g);
          m_phase   = 1;
          m_cur_bar = bar;
        end
      end
      1: if (rdy) begin m_phase = 2; m_issued++; end
      default: if (dn) begin m_phase = 0; if (m_cur_bar) m_bpend = 0; end
    endcase
    if (acc) begin
      if (c <= 4'd2) l1_m.push_back(mk(c, a));
      else if (c <= 4'd6) snp_m.push_back(mk(c, a));
      else if (c == 4'd8 || c == 4'd9) begin m_bpend = 1; m_bcode = c; end
      else if (m_dropped < 255) m_dropped++;
    end
  endtask

  task automatic send(input logic [3:0] c, input logic [AW-1:0] a, input bit rdy, input bit dn);
    bit acc;
    acc = 0;
    for (int i = 0; i < 60 && !acc; i++) step(1'b1, c, a, rdy, dn, acc);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout: got not-accepted expected accepted for code %0d", c);
    end
  endtask

  task automatic drain();
    bit acc;
    for (int i = 0; i < 300 && !model_idle(); i++) step(1'b0, 4'd0, '0, 1'b1, 1'b1, acc);
    if (!model_idle()) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got busy expected idle");
    end
  endtask

  task automatic check_order(input req_t exp_order[$]);
    check("order_len", seen.size(), exp_order.size());
    for (int i = 0; i < exp_order.size() && i < seen.size(); i++) check("order", seen[i], exp_order[i]);
  endtask

  // Monitor: pops the scoreboard at every handshake and checks hold stability.
  logic held = 1'b0;
  req_t hold_r;
  always @(negedge clk) begin
    req_t e;
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held && bus.l2_req_valid) begin
        check("hold_op", bus.l2_req_op, hold_r.op);
        check("hold_addr", bus.l2_req_addr, hold_r.addr);
      end
      held   = bus.l2_req_valid && !bus.l2_req_ready;
      hold_r = mk(bus.l2_req_op, bus.l2_req_addr);
      if (bus.l2_req_valid && bus.l2_req_ready) begin
        seen.push_back(mk(bus.l2_req_op, bus.l2_req_addr));
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue: got op %0d addr %0h expected none", bus.l2_req_op, bus.l2_req_addr);
        end else begin
          e = exp_q.pop_front();
          check("issue_op", bus.l2_req_op, e.op);
          check("issue_addr", bus.l2_req_addr, e.addr);
        end
      end
    end
  end

  initial begin
    bit   acc;
    req_t eo[$];
    bus.cmd_valid = 1'b0; bus.cmd_code = '0; bus.cmd_addr = '0;
    bus.l2_req_ready = 1'b0; bus.l2_done = 1'b0;
    model_reset();
    do_reset();

    // Single read with a 3-cycle stall
    seen.delete();
    step(1'b1, 4'd0, 32'h0000_1234, 1'b0, 1'b0, acc);
    repeat (4) step(1'b0, 4'd0, '0, 1'b0, 1'b0, acc);
    step(1'b0, 4'd0, '0, 1'b1, 1'b0, acc);
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, acc);
    drain();
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, acc);
    check("single_issued", issued_count, 16'd1);
    check("single_busy", busy, 1'b0);
    eo = '{}; eo.push_back(mk(4'd0, 32'h1234));
    check_order(eo);

    // Illegal codes
    step(1'b1, 4'd7, 32'h77, 1'b1, 1'b1, acc);
    step(1'b1, 4'd15, 32'hFF, 1'b1, 1'b1, acc);
    step(1'b0, 4'd0, '0, 1'b1, 1'b1, acc);
    check("dropped_two", dropped_count, 8'd2);
    check("illegal_no_issue", issued_count, 16'd1);

    // Snoop priority with starvation guard behind an in-flight op
    seen.delete();
    send(4'd0, 32'h100, 1'b0, 1'b0);
    send(4'd0, 32'hA0, 1'b0, 1'b0);
    send(4'd1, 32'hB0, 1'b0, 1'b0);
    send(4'd3, 32'h51, 1'b0, 1'b0);
    send(4'd4, 32'h52, 1'b0, 1'b0);
    send(4'd5, 32'h53, 1'b0, 1'b0);
    send(4'd6, 32'h54, 1'b0, 1'b0);
    send(4'd3, 32'h55, 1'b1, 1'b1);
    drain();
    eo = '{};
    eo.push_back(mk(4'd0, 32'h100)); eo.push_back(mk(4'd3, 32'h51));
    eo.push_back(mk(4'd4, 32'h52));  eo.push_back(mk(4'd5, 32'h53));
    eo.push_back(mk(4'd0, 32'hA0));  eo.push_back(mk(4'd6, 32'h54));
    eo.push_back(mk(4'd3, 32'h55));  eo.push_back(mk(4'd1, 32'hB0));
    check_order(eo);

    // Backpressure: one in flight, four queued, sixth blocked
    seen.delete();
    for (int i = 0; i < 5; i++) send(4'd1, 32'h200 + i, 1'b0, 1'b0);
    step(1'b1, 4'd1, 32'h205, 1'b0, 1'b0, acc);
    check("bp_blocked", acc, 1'b0);
    send(4'd1, 32'h205, 1'b1, 1'b1);
    drain();
    eo = '{};
    for (int i = 0; i < 6; i++) eo.push_back(mk(4'd1, 32'h200 + i));
    check_order(eo);

    // Barrier drains prior work and holds off the next command
    seen.delete();
    send(4'd1, 32'h100, 1'b0, 1'b0);
    send(4'd0, 32'h10, 1'b0, 1'b0);
    send(4'd4, 32'h20, 1'b0, 1'b0);
    send(4'd8, 32'hDEAD, 1'b0, 1'b0);
    send(4'd2, 32'h30, 1'b1, 1'b1);
    drain();
    eo = '{};
    eo.push_back(mk(4'd1, 32'h100)); eo.push_back(mk(4'd4, 32'h20));
    eo.push_back(mk(4'd0, 32'h10));  eo.push_back(mk(4'd8, 32'h0));
    eo.push_back(mk(4'd2, 32'h30));
    check_order(eo);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 5) < 3, 4'($urandom % 16), $urandom, ($urandom % 4) != 0, ($urandom % 3) == 0, acc);
    end
    drain();

    // Dropped counter saturation
    for (int i = 0; i < 300; i++) begin
      int r;
      r = $urandom_range(0, 6);
      step(1'b1, (r == 0) ? 4'd7 : 4'(9 + r), $urandom, 1'b1, 1'b1, acc);
    end
    step(1'b0, 4'd0, '0, 1'b1, 1'b1, acc);
    check("dropped_sat", dropped_count, 8'd255);

    // Reset while awaiting done; a late done is ignored
    send(4'd0, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 10 && m_phase != 2; i++) step(1'b0, 4'd0, '0, 1'b1, 1'b0, acc);
    check("reached_wait", m_phase, 2);
    do_reset();
    step(1'b0, 4'd0, '0, 1'b0, 1'b1, acc);
    step(1'b0, 4'd0, '0, 1'b0, 1'b0, acc);
    check("rst_valid", bus.l2_req_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_issued", issued_count, 16'd0);
    check("rst_dropped", dropped_count, 8'd0);

    drain();
    repeat (3) step(1'b0, 4'd0, '0, 1'b1, 1'b1, acc);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
